// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_HOST = 2'd2
   } rd_owner_t;

   localparam int STARVE_W = 4;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating contention counter: counts CPU wins over a waiting host, stops at limit.
module dmem_arb_starve_ctr
   import dmem_arb_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                clear,
   input  logic                inc,
   input  logic [STARVE_W-1:0] limit,
   output logic [STARVE_W-1:0] count,
   output logic                at_limit
);

   assign at_limit = (count == limit);

   always_ff @(posedge clock) begin
      if (reset || clear)
         count <= '0;
      else if (inc && !at_limit)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU fixed priority, host forced in after STARVE_LIMIT
// contended cycles. Optional perf counters under DMEM_ARB_PERF_EN.
//
// rd_owner   | meaning
// OWN_NONE   | no read returning this cycle
// OWN_CPU    | mem_rdata belongs to the CPU load issued last cycle
// OWN_HOST   | mem_rdata belongs to the host read issued last cycle
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
`ifdef DMEM_ARB_PERF_EN
   output logic [31:0]   stall_cycles,
   output logic [31:0]   host_xfers,
`endif
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

   logic                cpu_win;
   logic                host_win;
   logic                at_limit;
   logic [STARVE_W-1:0] starve_cnt;
   rd_owner_t           rd_owner;
   rd_owner_t           rd_owner_nxt;

   // Nothing is granted while reset is held, so no RAM access or read return is launched.
   always_comb begin
      cpu_win  = 1'b0;
      host_win = 1'b0;
      if (!reset) begin
         if (cpu_req && host_req) begin
            host_win = at_limit;
            cpu_win  = !at_limit;
         end else begin
            cpu_win  = cpu_req;
            host_win = host_req;
         end
      end
   end

   assign cpu_stall = cpu_req & ~cpu_win;
   assign host_gnt  = host_win;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_win) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (host_win) begin
         mem_en    = 1'b1;
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

   dmem_arb_starve_ctr u_starve (
      .clock    (clock),
      .reset    (reset),
      .clear    (host_win | ~host_req),
      .inc      (cpu_win & host_req),
      .limit    (LIMIT),
      .count    (starve_cnt),
      .at_limit (at_limit)
   );

   always_ff @(posedge clock) begin
      if (reset)
         rd_owner <= OWN_NONE;
      else
         rd_owner <= rd_owner_nxt;
   end

   always_comb begin
      rd_owner_nxt = OWN_NONE;
      if (cpu_win && !cpu_we)
         rd_owner_nxt = OWN_CPU;
      else if (host_win && !host_we)
         rd_owner_nxt = OWN_HOST;
   end

   // Gating with reset kills a read return that lands in the first reset cycle.
   assign cpu_rvalid  = (rd_owner == OWN_CPU)  && !reset;
   assign host_rvalid = (rd_owner == OWN_HOST) && !reset;
   assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
   assign host_rdata  = host_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles <= '0;
         host_xfers   <= '0;
      end else begin
         if (cpu_stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
         if (host_gnt && host_xfers != '1)
            host_xfers <= host_xfers + 1'b1;
      end
   end
`endif

   logic unused_cnt;
   assign unused_cnt = ^starve_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded random/directed bench for dmem_arbiter with a behavioural RAM.
module tb_dmem_arbiter;

   localparam int LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 0, cpu_we = 0;
   logic [31:0] cpu_addr = 0, cpu_wdata = 0;
   logic        cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        host_req = 0, host_we = 0;
   logic [31:0] host_addr = 0, host_wdata = 0;
   logic        host_gnt, host_rvalid;
   logic [31:0] host_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 0;
`ifdef DMEM_ARB_PERF_EN
   logic [31:0] stall_cycles, host_xfers;
   int unsigned m_stall = 0, m_hx = 0;
`endif

   dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
`ifdef DMEM_ARB_PERF_EN
      .stall_cycles(stall_cycles), .host_xfers(host_xfers),
`endif
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   // Behavioural single-port RAM, one-cycle read latency.
   logic [31:0] ram [256];
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr[9:2]];
      end
   end

   // Reference model state
   logic [31:0] ref_mem [256];
   int          m_cnt = 0;
   logic [31:0] exp_cpu_q[$], exp_host_q[$];
   bit          pend_cpu = 0, pend_host = 0;
   logic [31:0] pend_cpu_d = 0, pend_host_d = 0;
   bit          last_hgnt = 0;
   int          n_vec = 0, n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic init_mem();
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 32'h5A5A_0000 ^ (i * 32'h0101_0101);
         ref_mem[i] = 32'h5A5A_0000 ^ (i * 32'h0101_0101);
      end
      ram[0] = 32'hAAAA_0000; ref_mem[0] = 32'hAAAA_0000;
      ram[1] = 32'h0000_BBBB; ref_mem[1] = 32'h0000_BBBB;
      ram[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
   endtask

   // One clock cycle: drive after the edge, check combinational outputs mid-cycle.
   task automatic step(input bit rst, input bit creq, input bit cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input bit hreq, input bit hwe,
                       input logic [31:0] haddr, input logic [31:0] hwd);
      bit g_cpu, g_host;
      logic [31:0] e_addr, e_wd;
      bit e_we;
      @(posedge clock); #1;
      if (pend_cpu  && !rst) exp_cpu_q.push_back(pend_cpu_d);
      if (pend_host && !rst) exp_host_q.push_back(pend_host_d);
      pend_cpu = 0; pend_host = 0;
      reset = rst;
      cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
      host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
      @(negedge clock);
      g_cpu = 0; g_host = 0;
      if (!rst) begin
         if (creq && hreq) begin
            if (m_cnt == LIMIT) g_host = 1; else g_cpu = 1;
         end else begin
            g_cpu = creq; g_host = hreq;
         end
      end
      e_addr = g_cpu ? caddr : (g_host ? haddr : 32'h0);
      e_wd   = g_cpu ? cwd   : (g_host ? hwd   : 32'h0);
      e_we   = g_cpu ? cwe   : (g_host ? hwe   : 1'b0);
      chk("cpu_stall", cpu_stall, creq && !g_cpu);
      chk("host_gnt",  host_gnt,  g_host);
      chk("mem_en",    mem_en,    g_cpu || g_host);
      chk("mem_we",    mem_we,    e_we);
      chk("mem_addr",  mem_addr,  e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
`ifdef DMEM_ARB_PERF_EN
      chk("stall_cycles", stall_cycles, m_stall);
      chk("host_xfers",   host_xfers,   m_hx);
      if (rst) begin m_stall = 0; m_hx = 0; end
      else begin
         if (creq && !g_cpu) m_stall++;
         if (g_host) m_hx++;
      end
`endif
      if (g_cpu && !cwe)  begin pend_cpu = 1;  pend_cpu_d  = ref_mem[caddr[9:2]]; end
      if (g_host && !hwe) begin pend_host = 1; pend_host_d = ref_mem[haddr[9:2]]; end
      if (g_cpu && cwe)   ref_mem[caddr[9:2]] = cwd;
      if (g_host && hwe)  ref_mem[haddr[9:2]] = hwd;
      if (rst || !hreq || g_host) m_cnt = 0;
      else if (g_cpu && m_cnt < LIMIT) m_cnt++;
      last_hgnt = g_host;
   endtask

   // Monitor: every expected read return must appear exactly in its slot.
   always @(negedge clock) begin
      if (n_vec >= 0) begin
         chk("cpu_rvalid",  cpu_rvalid,  exp_cpu_q.size()  != 0);
         chk("host_rvalid", host_rvalid, exp_host_q.size() != 0);
         if (cpu_rvalid && exp_cpu_q.size() != 0)   chk("cpu_rdata", cpu_rdata, exp_cpu_q.pop_front());
         else if (!cpu_rvalid)                      chk("cpu_rdata_idle", cpu_rdata, 0);
         if (host_rvalid && exp_host_q.size() != 0) chk("host_rdata", host_rdata, exp_host_q.pop_front());
         else if (!host_rvalid)                     chk("host_rdata_idle", host_rdata, 0);
      end
   end

   initial begin
      bit hr, hw;
      logic [31:0] ha, hd;
      init_mem();
      // Requests during reset are never granted
      for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h10, 0, 1, 0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // CPU-only load of 0x10
      step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Sustained contention: host wins on the 5th and 10th cycles
      for (int i = 0; i < 12; i++) begin
         step(0, 1, 0, 32'(i * 4), 0, 1, 0, 32'h40, 0);
         chk("starve_slot", host_gnt, (i == 4) || (i == 9));
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Host write then CPU load of the same word
      step(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678);
      step(0, 1, 0, 32'h20, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Alternating host/CPU reads at full rate
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) step(0, 0, 0, 0, 0, 1, 0, 32'h0, 0);
         else            step(0, 1, 0, 32'h4, 0, 0, 0, 0, 0);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // CPU read followed by reset: return suppressed
      step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Random traffic; host holds its command until granted
      hr = 0; hw = 0; ha = 0; hd = 0;
      for (int i = 0; i < 600; i++) begin
         if (!hr || last_hgnt) begin
            hr = ($urandom_range(0, 2) != 0);
            hw = $urandom_range(0, 1);
            ha = 32'($urandom_range(0, 15)) << 2;
            hd = $urandom;
         end
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
              32'($urandom_range(0, 15)) << 2, $urandom, hr, hw, ha, hd);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("cpu_q_drained",  exp_cpu_q.size(),  0);
      chk("host_q_drained", exp_host_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
